// File: rtl/idct4_serial.sv
// rtl/idct4_serial.sv - serial-in, parallel-out 4-point inverse integer DCT (64/83/36 kernel)
// Collector -> even/odd butterfly register -> rounded, saturated output register.
module idct4_serial #(
    parameter int COEF_W = 16,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [COEF_W-1:0] s_coef,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [OUT_W-1:0]  m_x0,
    output logic signed [OUT_W-1:0]  m_x1,
    output logic signed [OUT_W-1:0]  m_x2,
    output logic signed [OUT_W-1:0]  m_x3,
    output logic                     m_busy
);

    // 9 guard bits cover 64*(y0+y2) + 119*|y| plus the rounding offset.
    localparam int ACC_W = COEF_W + 9;
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic signed [ACC_W-1:0] mul83(input logic signed [ACC_W-1:0] v);
        return (v <<< 6) + (v <<< 4) + (v <<< 1) + v;
    endfunction

    function automatic logic signed [ACC_W-1:0] mul36(input logic signed [ACC_W-1:0] v);
        return (v <<< 5) + (v <<< 2);
    endfunction

    function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] t;
        t = (v + RND) >>> SHIFT;
        if (t > SAT_MAX) begin
            t = SAT_MAX;
        end else if (t < SAT_MIN) begin
            t = SAT_MIN;
        end
        return t[OUT_W-1:0];
    endfunction

    logic        [1:0]        r_idx;
    logic signed [COEF_W-1:0] r_y [4];
    logic                     r_vec_full;
    logic                     r_s1_valid;
    logic signed [ACC_W-1:0]  r_e0, r_e1, r_o0, r_o1;
    logic                     r_m_valid;
    logic signed [OUT_W-1:0]  r_x0, r_x1, r_x2, r_x3;

    logic                     w_s_acc;
    logic                     w_s1_load;
    logic                     w_s2_load;
    logic signed [ACC_W-1:0]  w_y0, w_y1, w_y2, w_y3;
    logic signed [ACC_W-1:0]  w_e0, w_e1, w_o0, w_o1;
    logic signed [ACC_W-1:0]  w_x0, w_x1, w_x2, w_x3;

    // Stage 1 may reload in the same edge that stage 2 drains it.
    assign w_s_acc   = s_valid & ~r_vec_full;
    assign w_s2_load = r_s1_valid & (~r_m_valid | m_ready);
    assign w_s1_load = r_vec_full & (~r_s1_valid | w_s2_load);

    assign w_y0 = ACC_W'(r_y[0]);
    assign w_y1 = ACC_W'(r_y[1]);
    assign w_y2 = ACC_W'(r_y[2]);
    assign w_y3 = ACC_W'(r_y[3]);

    assign w_e0 = (w_y0 + w_y2) <<< 6;
    assign w_e1 = (w_y0 - w_y2) <<< 6;
    assign w_o0 = mul83(w_y1) + mul36(w_y3);
    assign w_o1 = mul36(w_y1) - mul83(w_y3);

    assign w_x0 = r_e0 + r_o0;
    assign w_x1 = r_e1 + r_o1;
    assign w_x2 = r_e1 - r_o1;
    assign w_x3 = r_e0 - r_o0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= 2'd0;
            r_vec_full <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_y[i] <= '0;
            end
        end else begin
            if (w_s_acc) begin
                r_y[r_idx] <= s_coef;
                r_idx      <= r_idx + 2'd1;
            end
            if (w_s1_load) begin
                r_vec_full <= 1'b0;
            end else if (w_s_acc && r_idx == 2'd3) begin
                r_vec_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_e0       <= '0;
            r_e1       <= '0;
            r_o0       <= '0;
            r_o1       <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= 1'b1;
                r_e0       <= w_e0;
                r_e1       <= w_e1;
                r_o0       <= w_o0;
                r_o1       <= w_o1;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_x0      <= '0;
            r_x1      <= '0;
            r_x2      <= '0;
            r_x3      <= '0;
        end else begin
            if (w_s2_load) begin
                r_m_valid <= 1'b1;
                r_x0      <= round_sat(w_x0);
                r_x1      <= round_sat(w_x1);
                r_x2      <= round_sat(w_x2);
                r_x3      <= round_sat(w_x3);
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign s_ready = ~r_vec_full;
    assign m_valid = r_m_valid;
    assign m_x0    = r_x0;
    assign m_x1    = r_x1;
    assign m_x2    = r_x2;
    assign m_x3    = r_x3;
    assign m_busy  = r_vec_full | r_s1_valid | r_m_valid | (r_idx != 2'd0);

endmodule

// File: tb/tb_idct4_serial.sv
// tb/tb_idct4_serial.sv - self-checking bench for idct4_serial against a matrix-form integer model
module tb_idct4_serial;

    localparam int COEF_W = 16;
    localparam int OUT_W  = 8;
    localparam int SHIFT  = 14;

    logic                     clk;
    logic                     rst_n;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [COEF_W-1:0] s_coef;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [OUT_W-1:0]  m_x0, m_x1, m_x2, m_x3;
    logic                     m_busy;

    idct4_serial #(.COEF_W(COEF_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_coef(s_coef),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_x0(m_x0), .m_x1(m_x1), .m_x2(m_x2), .m_x3(m_x3),
        .m_busy(m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    bit rnd_ready = 0;
    bit hold_prev = 0;
    int hold_x[4];

    // Inverse transform matrix: x[i] = sum_k C[k][i] * y[k]
    int cmat[4][4] = '{'{64, 64, 64, 64}, '{83, 36, -36, -83},
                       '{64, -64, -64, 64}, '{36, -83, 83, -36}};

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rsat(input int v);
        int t;
        t = (v + (1 <<< (SHIFT - 1))) >>> SHIFT;
        if (t > (2 ** (OUT_W - 1)) - 1) t = (2 ** (OUT_W - 1)) - 1;
        if (t < -(2 ** (OUT_W - 1))) t = -(2 ** (OUT_W - 1));
        return t;
    endfunction

    task automatic push_model(input int y0, input int y1, input int y2, input int y3);
        int y[4];
        y = '{y0, y1, y2, y3};
        for (int i = 0; i < 4; i++) begin
            int acc = 0;
            for (int k = 0; k < 4; k++) acc += cmat[k][i] * y[k];
            exp_q.push_back(rsat(acc));
        end
    endtask

    task automatic push_const(input int a, input int b, input int c, input int d);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
    endtask

    // Called and returns at posedge+1; handshake lands on the posedge after s_ready is seen.
    task automatic send(input int c);
        int t = 0;
        s_valid = 1'b1;
        s_coef  = COEF_W'(c);
        @(negedge clk);
        while (!s_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) check("s_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_vec(input int y0, input int y1, input int y2, input int y3);
        send(y0); send(y1); send(y2); send(y3);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || m_busy) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("busy_idle", int'(m_busy), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd_coef();
        if ($urandom_range(0, 3) == 0) return int'($signed(16'($urandom)));
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    // Output monitor: scoreboard pop on handshake, stability while stalled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_prev && m_valid) begin
                check("hold_x0", int'(m_x0), hold_x[0]);
                check("hold_x3", int'(m_x3), hold_x[3]);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() < 4) begin
                    check("unexpected_vec", 1, 0);
                end else begin
                    check("x0", int'(m_x0), exp_q.pop_front());
                    check("x1", int'(m_x1), exp_q.pop_front());
                    check("x2", int'(m_x2), exp_q.pop_front());
                    check("x3", int'(m_x3), exp_q.pop_front());
                end
            end
            hold_prev = m_valid && !m_ready;
            hold_x    = '{int'(m_x0), int'(m_x1), int'(m_x2), int'(m_x3)};
        end else begin
            hold_prev = 0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int dc_in[3]  = '{16384, 32767, -32768};
        int dc_out[3] = '{64, 127, -128};
        int t;

        rst_n = 1'b0; s_valid = 1'b0; s_coef = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", int'(s_ready), 1);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_busy", int'(m_busy), 0);
        check("rst_m_x0", int'(m_x0), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reference vector, latency and one-cycle s_ready gap
        push_const(10, 20, 30, 40);
        send_vec(6400, -2850, 0, -250);
        check("gap_s_ready_E", int'(s_ready), 0);
        check("lat_m_valid_E", int'(m_valid), 0);
        @(posedge clk);
        #1;
        check("gap_s_ready_E1", int'(s_ready), 1);
        check("lat_m_valid_E1", int'(m_valid), 0);
        @(posedge clk);
        #1;
        check("lat_m_valid_E2", int'(m_valid), 1);
        wait_drain();

        for (int i = 0; i < 3; i++) begin
            push_const(dc_out[i], dc_out[i], dc_out[i], dc_out[i]);
            send_vec(dc_in[i], 0, 0, 0);
            wait_drain();
        end

        // Three vectors against a stalled sink
        m_ready = 1'b0;
        for (int v = 0; v < 3; v++) begin
            int a = rnd_coef(), b = rnd_coef(), c = rnd_coef(), d = rnd_coef();
            push_model(a, b, c, d);
            send_vec(a, b, c, d);
        end
        for (int i = 0; i < 4; i++) begin
            check("full_s_ready", int'(s_ready), 0);
            check("full_busy", int'(m_busy), 1);
            @(posedge clk);
            #1;
        end
        check("full_x0", int'(m_x0), exp_q[0]);
        check("full_x1", int'(m_x1), exp_q[1]);
        check("full_x2", int'(m_x2), exp_q[2]);
        check("full_x3", int'(m_x3), exp_q[3]);
        m_ready = 1'b1;
        wait_drain();

        // Reset with a partial vector in the collector
        send(111);
        send(-222);
        rst_n = 1'b0;
        #1;
        check("rst_partial_busy", int'(m_busy), 0);
        check("rst_partial_s_ready", int'(s_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_const(10, 20, 30, 40);
        send_vec(6400, -2850, 0, -250);
        wait_drain();

        // Reset while a result is presented
        m_ready = 1'b0;
        push_const(10, 20, 30, 40);
        send_vec(6400, -2850, 0, -250);
        t = 0;
        while (!m_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("pre_rst_m_valid", int'(m_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_m_valid", int'(m_valid), 0);
        check("async_m_x0", int'(m_x0), 0);
        check("async_m_x2", int'(m_x2), 0);
        check("async_s_ready", int'(s_ready), 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ready = 1'b1;

        // Random traffic with input gaps and sink backpressure
        rnd_ready = 1;
        for (int v = 0; v < 1000; v++) begin
            int y[4];
            for (int k = 0; k < 4; k++) y[k] = rnd_coef();
            push_model(y[0], y[1], y[2], y[3]);
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                send(y[k]);
            end
        end
        rnd_ready = 0;
        @(posedge clk);
        #2;
        m_ready = 1'b1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
